// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue/write-back controller for the 16-bit combinational ALU.
//               Accepts instruction words over valid/ready, decodes ADD and
//               ADDI, reads operands from a 16x16 register file, presents
//               them to the ALU for one cycle, then writes the result back
//               and latches the ALU flags into the PSR.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_opext,
  input  logic [15:0] alu_S,
  input  logic [4:0]  alu_CLFZN,
  output logic [4:0]  psr,
  output logic        done,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  localparam logic [3:0] c_OP_ADD   = 4'b0000;
  localparam logic [3:0] c_EXT_ADD  = 4'b0101;
  localparam logic [3:0] c_OP_ADDI  = 4'b0101;

  state_t      r_state;
  logic        r_ready;
  logic [15:0] r_ir;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [4:0]  r_psr;
  logic        r_done;
  logic        r_illegal;
  logic [15:0] r_rf [16];

  logic [3:0]  w_rdest;
  logic [3:0]  w_rsrc;
  logic        w_is_add;
  logic        w_is_addi;
  logic [15:0] w_imm_sext;

  // Instruction register field decode
  assign w_rdest    = r_ir[11:8];
  assign w_rsrc     = r_ir[3:0];
  assign w_is_add   = (r_ir[15:12] == c_OP_ADD) && (r_ir[7:4] == c_EXT_ADD);
  assign w_is_addi  = (r_ir[15:12] == c_OP_ADDI);
  assign w_imm_sext = {{8{r_ir[7]}}, r_ir[7:0]};

  // Issue FSM: operand fetch, write-back, flag capture and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_ir      <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_psr     <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_ready <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_is_add || w_is_addi) begin
            r_opa   <= r_rf[w_rdest];
            r_opb   <= w_is_add ? r_rf[w_rsrc] : w_imm_sext;
            r_state <= S_EXEC;
          end else begin
            // Unsupported word: drop it without touching rf or psr
            r_illegal <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_rf[w_rdest] <= alu_S;
          r_psr         <= alu_CLFZN;
          r_done        <= 1'b1;
          r_ready       <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ALU drive comes straight from registers so it is stable through EXEC
  assign alu_A       = r_opa;
  assign alu_B       = r_opb;
  assign alu_opcode  = r_ir[15:12];
  assign alu_opext   = r_ir[7:4];

  assign instr_ready = r_ready;
  assign psr         = r_psr;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign dbg_data    = r_rf[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl with a
//               behavioural model of the 16-bit ALU (ADD/ADDI only).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_A, alu_B, alu_S;
  logic [3:0]  alu_opcode, alu_opext;
  logic [4:0]  alu_CLFZN;
  logic [4:0]  psr;
  logic        done, illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  // Observations captured by the issue helper
  logic        o_to, o_rdy_dec, o_rdy1, o_rdy2, o_done1, o_done2, o_ill1, o_ill2;
  logic [15:0] o_a, o_b, o_dbg1, o_dbg2;
  logic [3:0]  o_op, o_ext;
  logic [4:0]  o_psr2;

  alu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_opcode  (alu_opcode),
    .alu_opext   (alu_opext),
    .alu_S       (alu_S),
    .alu_CLFZN   (alu_CLFZN),
    .psr         (psr),
    .done        (done),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // ALU model: wrap-around add; Z on zero, F on signed overflow, C/L/N clear
  logic [15:0] m_sum;
  always_comb begin
    m_sum     = alu_A + alu_B;
    alu_S     = 16'hDEAD;
    alu_CLFZN = 5'b11111;
    if ((alu_opcode == 4'b0000 && alu_opext == 4'b0101) || alu_opcode == 4'b0101) begin
      alu_S     = m_sum;
      alu_CLFZN = {2'b00, (alu_A[15] == alu_B[15]) && (m_sum[15] != alu_A[15]),
                   (m_sum == 16'h0000), 1'b0};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single accepting edge and record what follows
  task automatic issue(input logic [15:0] w);
    int n;
    n    = 0;
    o_to = 1'b0;
    while (!instr_ready && n < 10) begin
      tick();
      n++;
    end
    if (!instr_ready) o_to = 1'b1;
    dbg_addr    = w[11:8];
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = 16'h0000;
    o_rdy_dec   = instr_ready;
    tick();
    o_a = alu_A; o_b = alu_B; o_op = alu_opcode; o_ext = alu_opext;
    o_done1 = done; o_ill1 = illegal; o_rdy1 = instr_ready; o_dbg1 = dbg_data;
    tick();
    o_done2 = done; o_ill2 = illegal; o_rdy2 = instr_ready; o_dbg2 = dbg_data;
    o_psr2  = psr;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000; dbg_addr = 4'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL reset_psr: got %b expected 00000", psr); end
    checks++; if (done !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b illegal=%b expected 0/0", done, illegal); end
    checks++; if (alu_A !== 16'h0 || alu_B !== 16'h0) begin errors++; $display("FAIL reset_ops: got A=%h B=%h expected 0000/0000", alu_A, alu_B); end
    checks++; if (alu_opcode !== 4'h0 || alu_opext !== 4'h0) begin errors++; $display("FAIL reset_ir: got op=%h ext=%h expected 0/0", alu_opcode, alu_opext); end
    for (int a = 0; a < 16; a++) begin
      dbg_addr = a[3:0];
      #1;
      checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL reset_rf[%0d]: got %h expected 0000", a, dbg_data); end
    end
  endtask

  task automatic test_addi();
    issue(16'h5105);
    checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL addi_ready_wait: got timeout=%b expected 0", o_to); end
    checks++; if (o_rdy_dec !== 1'b0 || o_rdy1 !== 1'b0) begin errors++; $display("FAIL addi_busy: got ready dec=%b exec=%b expected 0/0", o_rdy_dec, o_rdy1); end
    checks++; if (o_a !== 16'h0000 || o_b !== 16'h0005) begin errors++; $display("FAIL addi_ops: got A=%h B=%h expected 0000/0005", o_a, o_b); end
    checks++; if (o_op !== 4'h5 || o_ext !== 4'h0) begin errors++; $display("FAIL addi_opfields: got op=%h ext=%h expected 5/0", o_op, o_ext); end
    checks++; if (o_done1 !== 1'b0 || o_dbg1 !== 16'h0000) begin errors++; $display("FAIL addi_exec: got done=%b rf1=%h expected 0/0000", o_done1, o_dbg1); end
    checks++; if (o_done2 !== 1'b1 || o_rdy2 !== 1'b1 || o_ill2 !== 1'b0) begin errors++; $display("FAIL addi_retire: got done=%b ready=%b illegal=%b expected 1/1/0", o_done2, o_rdy2, o_ill2); end
    checks++; if (o_dbg2 !== 16'h0005 || o_psr2 !== 5'b00000) begin errors++; $display("FAIL addi_wb: got rf1=%h psr=%b expected 0005/00000", o_dbg2, o_psr2); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL addi_done_width: got %b expected 0", done); end
  endtask

  task automatic test_addi_neg();
    issue(16'h51FB);
    checks++; if (o_a !== 16'h0005 || o_b !== 16'hFFFB) begin errors++; $display("FAIL addineg_ops: got A=%h B=%h expected 0005/FFFB", o_a, o_b); end
    checks++; if (o_ext !== 4'hF) begin errors++; $display("FAIL addineg_ext: got %h expected F", o_ext); end
    checks++; if (o_dbg2 !== 16'h0000 || o_psr2 !== 5'b00010) begin errors++; $display("FAIL addineg_wb: got rf1=%h psr=%b expected 0000/00010", o_dbg2, o_psr2); end
  endtask

  task automatic test_add_overflow();
    issue(16'h5340);
    checks++; if (o_dbg2 !== 16'h0040 || o_psr2 !== 5'b00000) begin errors++; $display("FAIL add_seed: got rf3=%h psr=%b expected 0040/00000", o_dbg2, o_psr2); end
    for (int k = 0; k < 8; k++) issue(16'h0353);
    checks++; if (o_dbg2 !== 16'h4000 || o_psr2 !== 5'b00000) begin errors++; $display("FAIL add_x8: got rf3=%h psr=%b expected 4000/00000", o_dbg2, o_psr2); end
    issue(16'h0353);
    checks++; if (o_a !== 16'h4000 || o_b !== 16'h4000) begin errors++; $display("FAIL add_ovf_ops: got A=%h B=%h expected 4000/4000", o_a, o_b); end
    checks++; if (o_dbg2 !== 16'h8000 || o_psr2 !== 5'b00100) begin errors++; $display("FAIL add_ovf_wb: got rf3=%h psr=%b expected 8000/00100", o_dbg2, o_psr2); end
  endtask

  task automatic test_illegal();
    issue(16'h1103);
    checks++; if (o_ill1 !== 1'b1 || o_done1 !== 1'b0) begin errors++; $display("FAIL ill_pulse: got illegal=%b done=%b expected 1/0", o_ill1, o_done1); end
    checks++; if (o_rdy1 !== 1'b1) begin errors++; $display("FAIL ill_ready: got %b expected 1", o_rdy1); end
    checks++; if (o_ill2 !== 1'b0 || o_done2 !== 1'b0) begin errors++; $display("FAIL ill_after: got illegal=%b done=%b expected 0/0", o_ill2, o_done2); end
    checks++; if (o_dbg2 !== 16'h0000 || o_psr2 !== 5'b00100) begin errors++; $display("FAIL ill_state: got rf1=%h psr=%b expected 0000/00100", o_dbg2, o_psr2); end
    issue(16'h0343);
    checks++; if (o_ill1 !== 1'b1 || o_dbg2 !== 16'h8000) begin errors++; $display("FAIL ill_opext: got illegal=%b rf3=%h expected 1/8000", o_ill1, o_dbg2); end
  endtask

  task automatic test_back_to_back();
    int dn[$];
    logic both;
    both        = 1'b0;
    dbg_addr    = 4'd2;
    instr       = 16'h5207;
    instr_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (done === 1'b1) dn.push_back(k);
      if (done === 1'b1 && illegal === 1'b1) both = 1'b1;
    end
    checks++; if (dn.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d done pulses expected 3", dn.size()); end
    else begin
      checks++; if (dn[0] != 3 || dn[1] != 6 || dn[2] != 9) begin errors++; $display("FAIL b2b_spacing: got %0d,%0d,%0d expected 3,6,9", dn[0], dn[1], dn[2]); end
    end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL b2b_exclusive: got done&illegal=%b expected 0", both); end
    checks++; if (dbg_data !== 16'h0015 || psr !== 5'b00000) begin errors++; $display("FAIL b2b_wb: got rf2=%h psr=%b expected 0015/00000", dbg_data, psr); end
    tick(); tick();
    checks++; if (instr_ready !== 1'b0 || alu_B !== 16'h0007 || alu_A !== 16'h0015) begin errors++; $display("FAIL b2b_4th_exec: got ready=%b A=%h B=%h expected 0/0015/0007", instr_ready, alu_A, alu_B); end
    reset = 1'b1;
    #1;
    checks++; if (dbg_data !== 16'h0000 || instr_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rst_exec: got rf2=%h ready=%b done=%b expected 0000/1/0", dbg_data, instr_ready, done); end
    instr_valid = 1'b0;
    tick();
    reset = 1'b0;
    dn.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done === 1'b1) dn.push_back(k);
    end
    checks++; if (dn.size() != 0 || dbg_data !== 16'h0000) begin errors++; $display("FAIL rst_after: got done pulses=%0d rf2=%h expected 0/0000", dn.size(), dbg_data); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_addi_neg();
    test_add_overflow();
    test_illegal();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
